// File: rtl/weight_loader.sv
// weight_loader: writes a valid/ready stream of weight words to consecutive array addresses from a base, wrapping at RAM_DEPTH; 1-cycle write latency.
// Define WEIGHT_LOADER_CHECKSUM_EN to add port checksum, the modular sum of words accepted since the last accepted start.
module weight_loader #(
   parameter int BIT_WIDTH      = 31,
   parameter int RAM_DEPTH      = 32,
   parameter int RAM_ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [RAM_ADDR_WIDTH-1:0] base_addr,
   input  logic [RAM_ADDR_WIDTH:0]   num_words,
   input  logic                      s_valid,
   input  logic [BIT_WIDTH:0]        s_data,
   output logic                      s_ready,
   output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
   output logic                      mem_wren,
   output logic                      mem_ren,
   output logic [BIT_WIDTH:0]        mem_wrdat,
   output logic                      busy,
   output logic                      done,
   output logic                      err
`ifdef WEIGHT_LOADER_CHECKSUM_EN
   ,
   output logic [BIT_WIDTH:0]        checksum
`endif
);

   localparam int              AW        = RAM_ADDR_WIDTH;
   localparam logic [AW:0]     DEPTH_W   = (AW+1)'(RAM_DEPTH);
   localparam logic [AW:0]     CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0]   ADDR_ONE  = AW'(1);
   localparam logic [AW-1:0]   LAST_ADDR = AW'(RAM_DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] ptr;
   logic [AW:0]   count;
   logic [AW:0]   total;
   logic          cfg_ok;
   logic          accept;
   logic          reject;
   logic          beat;
   logic          last_beat;

   assign cfg_ok    = (num_words != '0) && (num_words <= DEPTH_W) && ({1'b0, base_addr} < DEPTH_W);
   assign accept    = (state == S_IDLE) && start && cfg_ok;
   assign reject    = (state == S_IDLE) && start && !cfg_ok;
   assign beat      = s_valid && s_ready;
   assign last_beat = beat && ((count + CNT_ONE) == total);
   assign busy      = (state != S_IDLE);
   assign mem_ren   = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_LOAD;
         S_LOAD:  if (last_beat) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // The write port is a registered copy of the accepted beat, so done lines up with the last write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_ready   <= 1'b0;
         mem_wren  <= 1'b0;
         mem_addr  <= '0;
         mem_wrdat <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         ptr       <= '0;
         count     <= '0;
         total     <= '0;
      end else begin
         mem_wren <= beat;
         done     <= last_beat;
         err      <= reject;
         if (accept) begin
            ptr     <= base_addr;
            total   <= num_words;
            count   <= '0;
            s_ready <= 1'b1;
         end
         if (beat) begin
            mem_addr  <= ptr;
            mem_wrdat <= s_data;
            ptr       <= (ptr == LAST_ADDR) ? '0 : ptr + ADDR_ONE;
            count     <= count + CNT_ONE;
            if (last_beat) s_ready <= 1'b0;
         end
      end
   end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         checksum <= '0;
      end else if (accept) begin
         checksum <= '0;
      end else if (beat) begin
         checksum <= checksum + s_data;
      end
   end
`endif

endmodule
